// File: rtl/as_pack.sv
// Shared constants and types for the instruction-memory boot loader.
package as_pack;

  localparam int imemdepth        = 64;
  localparam int instr_width      = 32;
  localparam int imem_addr_width  = $clog2(imemdepth) + 2;
  localparam int loader_len_bytes = 4;
  localparam int loader_cnt_width = $clog2(loader_len_bytes);

  typedef enum logic [2:0] {
    LEN,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/as_imem_loader_byte_assembler.sv
// 4-byte little-endian assembler: the first byte lands in [7:0], the strobe
// fires together with the 4th byte, and word_o already contains that byte.
module as_byte_assembler
  import as_pack::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             byte_i,
  input  logic                   valid_i,
  output logic [instr_width-1:0] word_o,
  output logic                   word_done_o
);

  logic [loader_cnt_width-1:0] cnt_reg;
  logic [23:0]                 shift_reg;

  // Only the three earlier bytes need storage; the last one is taken live.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else if (valid_i) begin
      cnt_reg   <= cnt_reg + 1'b1;
      shift_reg <= {byte_i, shift_reg[23:8]};
    end
  end

  assign word_o      = {byte_i, shift_reg};
  assign word_done_o = valid_i && (cnt_reg == loader_cnt_width'(loader_len_bytes - 1));

endmodule

// File: rtl/as_imem_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory write port.
// Optional trailing checksum byte is built in with AS_LOADER_CHECKSUM_EN.
module as_imem_loader
  import as_pack::*;
#(
  parameter int mdepth = imemdepth
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_valid_i,
  output logic                       rx_ready_o,
  output logic [imem_addr_width-1:0] addr_o,
  output logic [instr_width-1:0]     data_o,
  output logic                       wr_o,
  output logic                       cpu_rst_o,
  output logic                       done_o,
  output logic                       error_o
);

  localparam int idx_w = $clog2(mdepth) + 1;

  loader_state_t          state_reg;
  logic [idx_w-1:0]       len_reg;
  logic [idx_w-1:0]       idx_reg;
  logic [idx_w-1:0]       idx_next;
  logic                   accept;
  logic                   asm_valid;
  logic                   word_done;
  logic [instr_width-1:0] word;
`ifdef AS_LOADER_CHECKSUM_EN
  logic [7:0]             sum_reg;
`endif

  assign accept    = rx_valid_i && rx_ready_o;
  assign asm_valid = accept && ((state_reg == LEN) || (state_reg == DATA));
  assign idx_next  = idx_reg + 1'b1;

  as_byte_assembler u_asm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .byte_i      (rx_data_i),
    .valid_i     (asm_valid),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= LEN;
      rx_ready_o <= 1'b1;
      wr_o       <= 1'b0;
      addr_o     <= '0;
      data_o     <= '0;
      cpu_rst_o  <= 1'b1;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      len_reg    <= '0;
      idx_reg    <= '0;
`ifdef AS_LOADER_CHECKSUM_EN
      sum_reg    <= '0;
`endif
    end else begin
      wr_o <= 1'b0;
      case (state_reg)
        LEN: begin
          if (word_done) begin
            if (word > 32'(mdepth)) begin
              state_reg  <= ERR;
              rx_ready_o <= 1'b0;
              error_o    <= 1'b1;
            end else if (word == '0) begin
`ifdef AS_LOADER_CHECKSUM_EN
              state_reg  <= CHK;
`else
              state_reg  <= DONE;
              rx_ready_o <= 1'b0;
              cpu_rst_o  <= 1'b0;
              done_o     <= 1'b1;
`endif
            end else begin
              state_reg <= DATA;
              len_reg   <= word[idx_w-1:0];
              idx_reg   <= '0;
            end
          end
        end
        DATA: begin
`ifdef AS_LOADER_CHECKSUM_EN
          if (accept) sum_reg <= sum_reg + rx_data_i;
`endif
          if (word_done) begin
            state_reg  <= WRITE;
            rx_ready_o <= 1'b0;
            wr_o       <= 1'b1;
            addr_o     <= imem_addr_width'({idx_reg, 2'b00});
            data_o     <= word;
          end
        end
        WRITE: begin
          idx_reg <= idx_next;
          if (idx_next == len_reg) begin
`ifdef AS_LOADER_CHECKSUM_EN
            state_reg  <= CHK;
            rx_ready_o <= 1'b1;
`else
            state_reg  <= DONE;
            cpu_rst_o  <= 1'b0;
            done_o     <= 1'b1;
`endif
          end else begin
            state_reg  <= DATA;
            rx_ready_o <= 1'b1;
          end
        end
`ifdef AS_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            rx_ready_o <= 1'b0;
            if (rx_data_i == sum_reg) begin
              state_reg <= DONE;
              cpu_rst_o <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              state_reg <= ERR;
              error_o   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          // DONE and ERR hold until reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_as_imem_loader.sv
// Self-checking bench for as_imem_loader; works with or without AS_LOADER_CHECKSUM_EN.
module tb_as_imem_loader;
  import as_pack::*;

  localparam int MDEPTH = imemdepth;

  typedef struct packed {
    logic [imem_addr_width-1:0] addr;
    logic [31:0]                data;
  } wr_t;

  logic                       clk_i = 1'b0;
  logic                       rst_i = 1'b1;
  logic [7:0]                 rx_data_i = '0;
  logic                       rx_valid_i = 1'b0;
  logic                       rx_ready_o;
  logic [imem_addr_width-1:0] addr_o;
  logic [instr_width-1:0]     data_o;
  logic                       wr_o;
  logic                       cpu_rst_o;
  logic                       done_o;
  logic                       error_o;

  int total = 0;
  int bad = 0;

  logic [7:0] frame_q[$];
  wr_t        wr_q[$];
  wr_t        exp_q[$];
  bit         exp_done, exp_err;
  bit         wr_prev = 0;
  bit         double_wr = 0;

  as_imem_loader #(.mdepth(MDEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .wr_o       (wr_o),
    .cpu_rst_o  (cpu_rst_o),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory-side monitor: capture each write, flag back-to-back strobes.
  always @(negedge clk_i) begin
    if (wr_o) wr_q.push_back('{addr: addr_o, data: data_o});
    if (wr_o && wr_prev) double_wr = 1;
    wr_prev = wr_o;
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    rx_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries = 0;
    repeat (gap) @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && tries < 20) begin
      @(negedge clk_i);
      tries++;
    end
    if (!rx_ready_o) begin
      total++; bad++;
      $display("FAIL send_timeout: ready=%0b required 1", rx_ready_o);
    end else begin
      @(negedge clk_i);
    end
    rx_valid_i = 1'b0;
  endtask

  // Frame of n random words, with a trailing checksum when that feature is built in.
  task automatic build_frame(input int n, input bit bad_sum);
    logic [7:0] s = '0;
    logic [7:0] b;
    logic [31:0] nn = n;
    frame_q.delete();
    for (int i = 0; i < 4; i++) frame_q.push_back(nn[8*i +: 8]);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      s += b;
    end
`ifdef AS_LOADER_CHECKSUM_EN
    frame_q.push_back(bad_sum ? s + 8'd1 : s);
`else
    if (bad_sum) frame_q.push_back(s);
`endif
  endtask

  // Reference: interpret the frame purely from the byte-stream rules.
  task automatic model_frame();
    int unsigned n;
    logic [7:0] s = '0;
    exp_q.delete();
    exp_done = 0;
    exp_err = 0;
    n = {frame_q[3], frame_q[2], frame_q[1], frame_q[0]};
    if (n > MDEPTH) begin
      exp_err = 1;
      return;
    end
    for (int w = 0; w < int'(n); w++) begin
      logic [31:0] d = {frame_q[4+4*w+3], frame_q[4+4*w+2], frame_q[4+4*w+1], frame_q[4+4*w]};
      for (int k = 0; k < 4; k++) s += frame_q[4+4*w+k];
      exp_q.push_back('{addr: imem_addr_width'(w * 4), data: d});
    end
`ifdef AS_LOADER_CHECKSUM_EN
    exp_err  = (frame_q[4+4*n] != s);
    exp_done = !exp_err;
`else
    exp_done = 1;
`endif
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rx_ready_o !== 1'b1) begin bad++; $display("FAIL reset_rx_ready: got %0b want 1", rx_ready_o); end
    total++; if (wr_o !== 1'b0) begin bad++; $display("FAIL reset_wr: got %0b want 0", wr_o); end
    total++; if (addr_o !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", addr_o); end
    total++; if (data_o !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
    total++; if (cpu_rst_o !== 1'b1) begin bad++; $display("FAIL reset_cpu_rst: got %0b want 1", cpu_rst_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done_o); end
    total++; if (error_o !== 1'b0) begin bad++; $display("FAIL reset_error: got %0b want 0", error_o); end
    $display("reset: ready=%0b cpu_rst=%0b done=%0b error=%0b", rx_ready_o, cpu_rst_o, done_o, error_o);
  endtask

  task automatic test_basic();
    logic [7:0] bytes_a[12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    logic [7:0] s = '0;
    do_reset();
    wr_q.delete(); double_wr = 0;
    frame_q.delete();
    foreach (bytes_a[i]) frame_q.push_back(bytes_a[i]);
    for (int i = 4; i < 12; i++) s += bytes_a[i];
`ifdef AS_LOADER_CHECKSUM_EN
    frame_q.push_back(s);
`endif
    foreach (frame_q[i]) send_byte(frame_q[i], 0);
    repeat (3) @(negedge clk_i);
    total++; if (wr_q.size() != 2) begin bad++; $display("FAIL basic_count: got %0d want 2", wr_q.size()); end
    if (wr_q.size() == 2) begin
      total++; if (wr_q[0] !== {imem_addr_width'(0), 32'h00500113}) begin bad++; $display("FAIL basic_w0: got %h/%h want 0/00500113", wr_q[0].addr, wr_q[0].data); end
      total++; if (wr_q[1] !== {imem_addr_width'(4), 32'h00C00193}) begin bad++; $display("FAIL basic_w1: got %h/%h want 4/00c00193", wr_q[1].addr, wr_q[1].data); end
    end
    total++; if (done_o !== 1'b1 || cpu_rst_o !== 1'b0) begin bad++; $display("FAIL basic_done: got done=%0b cpu_rst=%0b want 1/0", done_o, cpu_rst_o); end
    $display("basic: writes=%0d done=%0b cpu_rst=%0b", wr_q.size(), done_o, cpu_rst_o);
  endtask

  task automatic test_overflow();
    logic [31:0] n = MDEPTH + 1;
    do_reset();
    wr_q.delete();
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 0);
    total++; if (error_o !== 1'b1) begin bad++; $display("FAIL ovf_error: got %0b want 1", error_o); end
    total++; if (rx_ready_o !== 1'b0) begin bad++; $display("FAIL ovf_ready: got %0b want 0", rx_ready_o); end
    total++; if (cpu_rst_o !== 1'b1) begin bad++; $display("FAIL ovf_cpu_rst: got %0b want 1", cpu_rst_o); end
    rx_valid_i = 1'b1; rx_data_i = 8'hAA;
    repeat (10) @(negedge clk_i);
    rx_valid_i = 1'b0;
    total++; if (wr_q.size() != 0 || done_o !== 1'b0) begin bad++; $display("FAIL ovf_nowrite: got writes=%0d done=%0b want 0/0", wr_q.size(), done_o); end
    $display("overflow: N=%0d error=%0b ready=%0b writes=%0d", n, error_o, rx_ready_o, wr_q.size());
  endtask

  // Random frames (incl. N=3 and N=mdepth) under three rx_valid gap patterns.
  task automatic test_stream();
    int lens[6] = '{3, 3, 1, 7, MDEPTH, 5};
    for (int t = 0; t < 6; t++) begin
      for (int g = 0; g < 3; g++) begin
        if (lens[t] == MDEPTH && g != 0) continue;
        build_frame(lens[t], 0);
        model_frame();
        do_reset();
        wr_q.delete(); double_wr = 0;
        foreach (frame_q[i]) send_byte(frame_q[i], (g == 0) ? 0 : (g == 1) ? int'($urandom_range(0, 4)) : 9);
        repeat (3) @(negedge clk_i);
        total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL stream_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
          total++;
          if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL stream_word%0d: got %h/%h want %h/%h", i, wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data); end
        end
        total++; if (done_o !== exp_done || error_o !== exp_err) begin bad++; $display("FAIL stream_status: got done=%0b err=%0b want %0b/%0b", done_o, error_o, exp_done, exp_err); end
        total++; if (cpu_rst_o !== !exp_done || rx_ready_o !== 1'b0) begin bad++; $display("FAIL stream_ctl: got cpu_rst=%0b ready=%0b want %0b/0", cpu_rst_o, rx_ready_o, !exp_done); end
        total++; if (double_wr) begin bad++; $display("FAIL stream_pulse: got back-to-back wr want single-cycle"); end
        $display("stream: N=%0d gap_mode=%0d writes=%0d done=%0b", lens[t], g, wr_q.size(), done_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] tail[8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h37, 8'h02, 8'h00, 8'h00};
    wr_t first;
    build_frame(2, 0);
    do_reset();
    wr_q.delete();
    for (int i = 0; i < 10; i++) send_byte(frame_q[i], 0);
    first = '{addr: '0, data: {frame_q[7], frame_q[6], frame_q[5], frame_q[4]}};
    do_reset();
    foreach (tail[i]) send_byte(tail[i], 0);
`ifdef AS_LOADER_CHECKSUM_EN
    send_byte(8'h39, 0);
`endif
    repeat (3) @(negedge clk_i);
    total++; if (wr_q.size() != 2) begin bad++; $display("FAIL rstmid_count: got %0d want 2", wr_q.size()); end
    if (wr_q.size() == 2) begin
      total++; if (wr_q[0] !== first) begin bad++; $display("FAIL rstmid_w0: got %h/%h want %h/%h", wr_q[0].addr, wr_q[0].data, first.addr, first.data); end
      total++; if (wr_q[1] !== {imem_addr_width'(0), 32'h00000237}) begin bad++; $display("FAIL rstmid_last: got %h/%h want 0/00000237", wr_q[1].addr, wr_q[1].data); end
    end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL rstmid_done: got %0b want 1", done_o); end
    $display("reset_mid: writes=%0d done=%0b", wr_q.size(), done_o);
  endtask

  task automatic test_zero();
    do_reset();
    wr_q.delete();
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
`ifdef AS_LOADER_CHECKSUM_EN
    total++; if (done_o !== 1'b0 || rx_ready_o !== 1'b1) begin bad++; $display("FAIL zero_chk_wait: got done=%0b ready=%0b want 0/1", done_o, rx_ready_o); end
    send_byte(8'h00, 0);
    total++; if (done_o !== 1'b1 || error_o !== 1'b0) begin bad++; $display("FAIL zero_sum_ok: got done=%0b err=%0b want 1/0", done_o, error_o); end
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    total++; if (done_o !== 1'b0 || error_o !== 1'b1) begin bad++; $display("FAIL zero_sum_bad: got done=%0b err=%0b want 0/1", done_o, error_o); end
`else
    total++; if (done_o !== 1'b1 || cpu_rst_o !== 1'b0) begin bad++; $display("FAIL zero_done: got done=%0b cpu_rst=%0b want 1/0", done_o, cpu_rst_o); end
    total++; if (rx_ready_o !== 1'b0) begin bad++; $display("FAIL zero_ready: got %0b want 0", rx_ready_o); end
`endif
    total++; if (wr_q.size() != 0) begin bad++; $display("FAIL zero_nowrite: got %0d want 0", wr_q.size()); end
    $display("zero: done=%0b error=%0b writes=%0d", done_o, error_o, wr_q.size());
  endtask

  task automatic test_checksum();
`ifdef AS_LOADER_CHECKSUM_EN
    logic [7:0] w[4] = '{8'h13, 8'h01, 8'h50, 8'h00};
    logic [7:0] s = '0;
    foreach (w[i]) s += w[i];
    for (int bad_sum = 0; bad_sum < 2; bad_sum++) begin
      do_reset();
      send_byte(8'h01, 0);
      for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
      foreach (w[i]) send_byte(w[i], 0);
      send_byte(bad_sum ? s + 8'd1 : s, 0);
      total++; if (done_o !== !bad_sum[0] || error_o !== bad_sum[0]) begin bad++; $display("FAIL chk_status%0d: got done=%0b err=%0b want %0b/%0b", bad_sum, done_o, error_o, !bad_sum[0], bad_sum[0]); end
      total++; if (cpu_rst_o !== bad_sum[0]) begin bad++; $display("FAIL chk_cpu_rst%0d: got %0b want %0b", bad_sum, cpu_rst_o, bad_sum[0]); end
      $display("checksum: corrupt=%0d done=%0b error=%0b", bad_sum, done_o, error_o);
    end
    build_frame(4, 1);
    model_frame();
    do_reset();
    foreach (frame_q[i]) send_byte(frame_q[i], int'($urandom_range(0, 3)));
    total++; if (error_o !== exp_err || done_o !== exp_done) begin bad++; $display("FAIL chk_random: got done=%0b err=%0b want %0b/%0b", done_o, error_o, exp_done, exp_err); end
    $display("checksum: random corrupt frame error=%0b", error_o);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stream();
    test_reset_mid();
    test_zero();
    test_checksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
